// File: rtl/cp0_pkg.sv
// cp0_pkg: shared definitions for the coprocessor-0 controller.
// Holds CP0 register numbers, exception codes, Status/Cause bit positions
// and the bit order of the WB exception vector {sys, mfc0, mtc0, eret}.
package cp0_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned EXC_W    = 5;
    localparam int unsigned IM_W     = 8;
    localparam int unsigned IP_HW_W  = 6;
    localparam int unsigned IP_SW_W  = 2;

    // CP0 register numbers (rd field of mfc0/mtc0)
    localparam logic [REG_W-1:0] REG_COUNT   = 5'd9;
    localparam logic [REG_W-1:0] REG_COMPARE = 5'd11;
    localparam logic [REG_W-1:0] REG_STATUS  = 5'd12;
    localparam logic [REG_W-1:0] REG_CAUSE   = 5'd13;
    localparam logic [REG_W-1:0] REG_EPC     = 5'd14;

    // Exception codes
    localparam logic [EXC_W-1:0] EXC_INT = 5'h00;
    localparam logic [EXC_W-1:0] EXC_SYS = 5'h08;

    // Status bit positions
    localparam int unsigned ST_BEV   = 22;
    localparam int unsigned ST_IM_LO = 8;
    localparam int unsigned ST_EXL   = 1;
    localparam int unsigned ST_IE    = 0;

    // Cause bit positions
    localparam int unsigned CA_BD       = 31;
    localparam int unsigned CA_TI       = 30;
    localparam int unsigned CA_IP_HW_LO = 10;
    localparam int unsigned CA_IP_SW_LO = 8;
    localparam int unsigned CA_EXC_LO   = 2;

    // Exception vector of the WB instruction, MSB first
    typedef struct packed {
        logic sys;
        logic mfc0;
        logic mtc0;
        logic eret;
    } c0_exc_t;

endpackage

// File: rtl/cp0_ctrl_if.sv
// cp0_ctrl_if: WB-stage bus between the pipeline and the CP0 controller.
// master: pipeline side (drives WB instruction info, receives flush/read data).
// slave : CP0 side.
//   c0_exception {sys,mfc0,mtc0,eret}, c0_int, c0_addr, c0_wdata, c0_wb_valid,
//   c0_wb_bd, c0_wb_pc, ext_int   -> towards CP0
//   c0_valid, c0_res, flush, flush_pc, int_pending -> towards pipeline
interface cp0_ctrl_if;
    import cp0_pkg::*;

    c0_exc_t             c0_exception;
    logic                c0_int;
    logic [REG_W-1:0]    c0_addr;
    logic [DATA_W-1:0]   c0_wdata;
    logic                c0_wb_valid;
    logic                c0_wb_bd;
    logic [DATA_W-1:0]   c0_wb_pc;
    logic [IP_HW_W-1:0]  ext_int;

    logic                c0_valid;
    logic [DATA_W-1:0]   c0_res;
    logic                flush;
    logic [DATA_W-1:0]   flush_pc;
    logic                int_pending;

    modport master (
        output c0_exception, c0_int, c0_addr, c0_wdata, c0_wb_valid,
               c0_wb_bd, c0_wb_pc, ext_int,
        input  c0_valid, c0_res, flush, flush_pc, int_pending
    );

    modport slave (
        input  c0_exception, c0_int, c0_addr, c0_wdata, c0_wb_valid,
               c0_wb_bd, c0_wb_pc, ext_int,
        output c0_valid, c0_res, flush, flush_pc, int_pending
    );

endinterface

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer with clock divider and timer-interrupt flag.
// Ports: clk, reset (sync, active-high), wr_count/wr_compare (committed mtc0
// strobes), wdata (mtc0 data), count/compare (register values), ti (timer
// interrupt, sticky until Compare is written).
module cp0_timer #(
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_count,
    input  logic        wr_compare,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam int unsigned DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(COUNT_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic             tick;
    logic [31:0]      count_next;

    // Divider wrap and post-update Count; an mtc0 Count overrides the tick
    always_comb begin
        tick       = (div_q == DIV_MAX);
        count_next = count;
        if (wr_count) begin
            count_next = wdata;
        end else if (tick) begin
            count_next = count + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q   <= '0;
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            if (wr_count || tick) begin
                div_q <= '0;
            end else begin
                div_q <= DIV_W'(div_q + 1'b1);
            end
            count <= count_next;
            if (wr_compare) begin
                compare <= wdata;
            end
            // Compare write clears TI and wins over a coincident match
            if (wr_compare) begin
                ti <= 1'b0;
            end else if (count_next == compare) begin
                ti <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: coprocessor-0 controller beside the WB stage of the 5-stage MIPS
// pipeline. Owns Status, Cause, EPC (and Count/Compare with the timer),
// services mfc0/mtc0, sequences exception entry and eret, drives the
// pipeline flush/redirect and the interrupt-pending request.
// Ports: clk, reset (sync, active-high), bus (cp0_ctrl_if.slave).
// Build option: define CP0_TIMER_EN to implement Count/Compare/TI via
// cp0_timer; otherwise registers 9/11 read 0 and TI is constant 0.
module cp0_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] EX_ENTRY = 32'hBFC00380
`ifdef CP0_TIMER_EN
    ,
    parameter int unsigned COUNT_DIV = 2
`endif
) (
    input  logic       clk,
    input  logic       reset,
    cp0_ctrl_if.slave  bus
);

    c0_exc_t             exc;
    logic                ex;
    logic                er;
    logic                wr;
    logic                wr_status;
    logic                wr_cause;
    logic                wr_epc;
    logic [DATA_W-1:0]   epc_in;

    logic [IM_W-1:0]     im;
    logic                exl;
    logic                ie;
    logic                bd;
    logic [IP_HW_W-1:0]  ip_hw;
    logic [IP_SW_W-1:0]  ip_sw;
    logic [EXC_W-1:0]    exc_code;
    logic [DATA_W-1:0]   epc;
    logic                ti;

    logic [DATA_W-1:0]   status_rd;
    logic [DATA_W-1:0]   cause_rd;
    logic [DATA_W-1:0]   rd_data;

    // Event decode; exception outranks eret and mtc0 on the same instruction
    always_comb begin
        exc       = bus.c0_exception;
        ex        = bus.c0_wb_valid & (bus.c0_int | exc.sys);
        er        = bus.c0_wb_valid & exc.eret & ~ex;
        wr        = bus.c0_wb_valid & exc.mtc0 & ~ex;
        wr_status = wr & (bus.c0_addr == REG_STATUS);
        wr_cause  = wr & (bus.c0_addr == REG_CAUSE);
        wr_epc    = wr & (bus.c0_addr == REG_EPC);
        epc_in    = bus.c0_wb_bd ? DATA_W'(bus.c0_wb_pc - 32'd4) : bus.c0_wb_pc;
    end

`ifdef CP0_TIMER_EN
    logic [DATA_W-1:0] count;
    logic [DATA_W-1:0] compare;

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .wr_count   (wr & (bus.c0_addr == REG_COUNT)),
        .wr_compare (wr & (bus.c0_addr == REG_COMPARE)),
        .wdata      (bus.c0_wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );
`else
    assign ti = 1'b0;
`endif

    // Privileged state commit
    always_ff @(posedge clk) begin
        if (reset) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip_hw    <= '0;
            ip_sw    <= '0;
            exc_code <= '0;
            epc      <= '0;
        end else begin
            // Hardware interrupt lines (IP7 shares with the timer) sampled every cycle
            ip_hw <= {bus.ext_int[5] | ti, bus.ext_int[4:0]};

            if (ex) begin
                exl      <= 1'b1;
                exc_code <= bus.c0_int ? EXC_INT : EXC_SYS;
            end else if (er) begin
                exl <= 1'b0;
            end else if (wr_status) begin
                exl <= bus.c0_wdata[ST_EXL];
            end

            // A nested exception keeps the original EPC/BD
            if (ex && !exl) begin
                epc <= epc_in;
                bd  <= bus.c0_wb_bd;
            end else if (wr_epc) begin
                epc <= bus.c0_wdata;
            end

            if (wr_status) begin
                im <= bus.c0_wdata[ST_IM_LO +: IM_W];
                ie <= bus.c0_wdata[ST_IE];
            end

            if (wr_cause) begin
                ip_sw <= bus.c0_wdata[CA_IP_SW_LO +: IP_SW_W];
            end
        end
    end

    // Architectural views of Status/Cause and the mfc0 read mux
    always_comb begin
        status_rd                     = '0;
        status_rd[ST_BEV]             = 1'b1;
        status_rd[ST_IM_LO +: IM_W]   = im;
        status_rd[ST_EXL]             = exl;
        status_rd[ST_IE]              = ie;

        cause_rd                          = '0;
        cause_rd[CA_BD]                   = bd;
        cause_rd[CA_TI]                   = ti;
        cause_rd[CA_IP_HW_LO +: IP_HW_W]  = ip_hw;
        cause_rd[CA_IP_SW_LO +: IP_SW_W]  = ip_sw;
        cause_rd[CA_EXC_LO +: EXC_W]      = exc_code;

        case (bus.c0_addr)
            REG_STATUS:  rd_data = status_rd;
            REG_CAUSE:   rd_data = cause_rd;
            REG_EPC:     rd_data = epc;
`ifdef CP0_TIMER_EN
            REG_COUNT:   rd_data = count;
            REG_COMPARE: rd_data = compare;
`endif
            default:     rd_data = '0;
        endcase
    end

    // Outputs are combinational; held at their idle values while in reset
    assign bus.c0_valid    = ~reset & bus.c0_wb_valid & exc.mfc0 & ~ex;
    assign bus.c0_res      = reset ? '0 : rd_data;
    assign bus.flush       = ~reset & (ex | er);
    assign bus.flush_pc    = (reset | ex) ? EX_ENTRY : epc;
    assign bus.int_pending = ~reset & ie & ~exl & (|({ip_hw, ip_sw} & im));

endmodule

// File: tb/tb_cp0_ctrl.sv
// tb_cp0_ctrl: self-checking bench for cp0_ctrl. A stimulus table of WB
// instructions with expected outputs is applied one per cycle; expectations
// travel through a scoreboard queue and are compared mid-cycle.
module tb_cp0_ctrl;

    localparam logic [31:0] EXV = 32'hBFC00380;
    localparam logic [3:0] SYS  = 4'b1000;
    localparam logic [3:0] MFC0 = 4'b0100;
    localparam logic [3:0] MTC0 = 4'b0010;
    localparam logic [3:0] ERET = 4'b0001;
    localparam logic [4:0] R_COUNT   = 5'd9;
    localparam logic [4:0] R_COMPARE = 5'd11;
    localparam logic [4:0] R_STATUS  = 5'd12;
    localparam logic [4:0] R_CAUSE   = 5'd13;
    localparam logic [4:0] R_EPC     = 5'd14;

    typedef struct {
        logic        valid;
        logic [3:0]  exc;
        logic        cint;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        bd;
        logic [31:0] pc;
        logic [5:0]  ext;
        logic        ev;
        logic [31:0] eres;
        logic        ef;
        logic [31:0] epc;
        logic        eip;
    } vec_t;

    typedef struct {
        int          idx;
        logic        ev;
        logic [31:0] eres;
        logic        ef;
        logic [31:0] epc;
        logic        eip;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t q[$];
    vec_t tbl[$];

    cp0_ctrl_if bus();

    cp0_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic valid, input logic [3:0] exc, input logic cint,
                                input logic [4:0] addr, input logic [31:0] wdata,
                                input logic bd, input logic [31:0] pc, input logic [5:0] ext,
                                input logic ev, input logic [31:0] eres,
                                input logic ef, input logic [31:0] epc, input logic eip);
        vec_t v;
        v.valid = valid; v.exc = exc; v.cint = cint; v.addr = addr; v.wdata = wdata;
        v.bd = bd; v.pc = pc; v.ext = ext;
        v.ev = ev; v.eres = eres; v.ef = ef; v.epc = epc; v.eip = eip;
        return v;
    endfunction

    function automatic vec_t rd(input logic [4:0] addr, input logic [31:0] eres,
                                input logic eip, input logic [5:0] ext);
        return mk(1'b1, MFC0, 1'b0, addr, 32'h0, 1'b0, 32'h0, ext, 1'b1, eres, 1'b0, 32'h0, eip);
    endfunction

    function automatic vec_t wrr(input logic [4:0] addr, input logic [31:0] data, input logic eip);
        return mk(1'b1, MTC0, 1'b0, addr, data, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 32'h0, eip);
    endfunction

    function automatic vec_t exr(input logic [3:0] exc, input logic [31:0] pc, input logic bd,
                                 input logic [31:0] epc, input logic eip);
        return mk(1'b1, exc, 1'b0, 5'd0, 32'h0, bd, pc, 6'h0, 1'b0, 32'h0, 1'b1, epc, eip);
    endfunction

    function automatic vec_t idle(input logic [5:0] ext, input logic eip);
        return mk(1'b0, 4'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, ext, 1'b0, 32'h0, 1'b0, 32'h0, eip);
    endfunction

    task automatic drive(input vec_t v);
        bus.c0_wb_valid  = v.valid;
        bus.c0_exception = v.exc;
        bus.c0_int       = v.cint;
        bus.c0_addr      = v.addr;
        bus.c0_wdata     = v.wdata;
        bus.c0_wb_bd     = v.bd;
        bus.c0_wb_pc     = v.pc;
        bus.ext_int      = v.ext;
    endtask

    // One WB cycle: drive after the edge, compare at the falling edge
    task automatic step(input vec_t v, input int idx);
        exp_t e;
        drive(v);
        q.push_back('{idx: idx, ev: v.ev, eres: v.eres, ef: v.ef, epc: v.epc, eip: v.eip});
        @(negedge clk);
        e = q.pop_front();
        chk($sformatf("row%0d flush", e.idx), 32'(bus.flush), 32'(e.ef));
        chk($sformatf("row%0d c0_valid", e.idx), 32'(bus.c0_valid), 32'(e.ev));
        chk($sformatf("row%0d int_pending", e.idx), 32'(bus.int_pending), 32'(e.eip));
        if (e.ef) chk($sformatf("row%0d flush_pc", e.idx), bus.flush_pc, e.epc);
        if (e.ev) chk($sformatf("row%0d c0_res", e.idx), bus.c0_res, e.eres);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int edges;
        logic found;
        checks = 0;
        errors = 0;

        // Reset: outputs idle even with a valid sys+mfc0 in WB
        reset = 1'b1;
        drive(mk(1'b1, SYS | MFC0, 1'b0, R_STATUS, 32'h0, 1'b0, 32'h0, 6'h0,
                 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset flush", 32'(bus.flush), 32'h0);
        chk("reset c0_valid", 32'(bus.c0_valid), 32'h0);
        chk("reset c0_res", bus.c0_res, 32'h0);
        chk("reset flush_pc", bus.flush_pc, EXV);
        chk("reset int_pending", 32'(bus.int_pending), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

`ifdef CP0_TIMER_EN
        // Park Compare far away so the reset-time Count==Compare match clears
        step(wrr(R_COMPARE, 32'hFFFF_0000, 1'b0), 90);
        step(idle(6'h0, 1'b0), 91);
        step(idle(6'h0, 1'b0), 92);
`endif

        tbl.push_back(rd(R_STATUS, 32'h0040_0000, 1'b0, 6'h0));                 // 0
        tbl.push_back(rd(R_CAUSE,  32'h0000_0000, 1'b0, 6'h0));                 // 1
        tbl.push_back(rd(R_EPC,    32'h0000_0000, 1'b0, 6'h0));                 // 2
        tbl.push_back(exr(SYS, 32'hBFC0_0100, 1'b0, EXV, 1'b0));                // 3
        tbl.push_back(rd(R_EPC,    32'hBFC0_0100, 1'b0, 6'h0));                 // 4
        tbl.push_back(rd(R_STATUS, 32'h0040_0002, 1'b0, 6'h0));                 // 5
        tbl.push_back(rd(R_CAUSE,  32'h0000_0020, 1'b0, 6'h0));                 // 6
        tbl.push_back(wrr(R_STATUS, 32'h0, 1'b0));                              // 7
        tbl.push_back(exr(SYS, 32'h8000_1004, 1'b1, EXV, 1'b0));                // 8
        tbl.push_back(rd(R_EPC,    32'h8000_1000, 1'b0, 6'h0));                 // 9
        tbl.push_back(rd(R_CAUSE,  32'h8000_0020, 1'b0, 6'h0));                 // 10
        tbl.push_back(wrr(R_EPC, 32'h8000_2000, 1'b0));                         // 11
        tbl.push_back(exr(ERET, 32'h0, 1'b0, 32'h8000_2000, 1'b0));             // 12
        tbl.push_back(rd(R_STATUS, 32'h0040_0000, 1'b0, 6'h0));                 // 13
        tbl.push_back(wrr(R_STATUS, 32'hFFFF_FFFF, 1'b0));                      // 14
        tbl.push_back(rd(R_STATUS, 32'h0040_FF03, 1'b0, 6'h0));                 // 15
        tbl.push_back(exr(SYS, 32'h8000_3000, 1'b0, EXV, 1'b0));                // 16
        tbl.push_back(rd(R_EPC,    32'h8000_2000, 1'b0, 6'h0));                 // 17
        tbl.push_back(rd(R_STATUS, 32'h0040_FF03, 1'b0, 6'h0));                 // 18
        tbl.push_back(rd(R_CAUSE,  32'h8000_0020, 1'b0, 6'h0));                 // 19
        tbl.push_back(exr(ERET, 32'h0, 1'b0, 32'h8000_2000, 1'b0));             // 20
        tbl.push_back(rd(R_STATUS, 32'h0040_FF01, 1'b0, 6'h0));                 // 21
        tbl.push_back(wrr(R_CAUSE, 32'hFFFF_FFFF, 1'b0));                       // 22
        tbl.push_back(rd(R_CAUSE,  32'h8000_0320, 1'b1, 6'h0));                 // 23
        tbl.push_back(wrr(R_CAUSE, 32'h0, 1'b1));                               // 24
        tbl.push_back(idle(6'h01, 1'b0));                                       // 25
        tbl.push_back(rd(R_CAUSE,  32'h8000_0420, 1'b1, 6'h01));                // 26
        tbl.push_back(mk(1'b1, SYS | MFC0 | MTC0, 1'b1, R_STATUS, 32'h0, 1'b0,  // 27
                         32'h8000_4008, 6'h0, 1'b0, 32'h0, 1'b1, EXV, 1'b1));
        tbl.push_back(rd(R_STATUS, 32'h0040_FF03, 1'b0, 6'h0));                 // 28
        tbl.push_back(rd(R_CAUSE,  32'h0000_0000, 1'b0, 6'h0));                 // 29
        tbl.push_back(rd(R_EPC,    32'h8000_4008, 1'b0, 6'h0));                 // 30
        tbl.push_back(mk(1'b0, MFC0, 1'b0, R_STATUS, 32'h0, 1'b0, 32'h0, 6'h0,  // 31
                         1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
        tbl.push_back(exr(SYS | ERET, 32'h8000_5000, 1'b0, EXV, 1'b0));         // 32
        tbl.push_back(rd(5'd5,     32'h0000_0000, 1'b0, 6'h0));                 // 33
        tbl.push_back(rd(R_STATUS, 32'h0040_FF03, 1'b0, 6'h0));                 // 34
        tbl.push_back(rd(R_EPC,    32'h8000_4008, 1'b0, 6'h0));                 // 35

        foreach (tbl[i]) step(tbl[i], i);

        // Reset in the middle of operation
        reset = 1'b1;
        drive(exr(SYS, 32'h8000_6000, 1'b0, EXV, 1'b0));
        @(negedge clk);
        chk("midreset flush", 32'(bus.flush), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(rd(R_CAUSE,  32'h0000_0000, 1'b0, 6'h0), 200);
        step(rd(R_STATUS, 32'h0040_0000, 1'b0, 6'h0), 201);
        step(rd(R_EPC,    32'h0000_0000, 1'b0, 6'h0), 202);

`ifdef CP0_TIMER_EN
        step(wrr(R_COMPARE, 32'd10, 1'b0), 100);
        step(wrr(R_COUNT, 32'd0, 1'b0), 101);
        step(wrr(R_STATUS, 32'h0000_8001, 1'b0), 102);
        // Count hits 10 after 20 edges (divider 2), IP7 follows one edge later
        edges = 1;
        found = 1'b0;
        while (!found && edges < 60) begin
            drive(idle(6'h0, 1'b0));
            @(negedge clk);
            if (bus.int_pending) begin
                found = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                edges++;
            end
        end
        chk("timer irq latency", 32'(edges), 32'd21);
        if (found) begin
            @(posedge clk);
            #1;
        end
        step(rd(R_CAUSE, 32'h4000_8000, 1'b1, 6'h0), 103);
        step(wrr(R_COMPARE, 32'h0001_0000, 1'b1), 104);
        step(rd(R_CAUSE, 32'h0000_8000, 1'b1, 6'h0), 105);
        step(rd(R_CAUSE, 32'h0000_0000, 1'b0, 6'h0), 106);
        step(rd(R_COMPARE, 32'h0001_0000, 1'b0, 6'h0), 107);
`else
        step(wrr(R_COUNT, 32'd5, 1'b0), 100);
        step(wrr(R_COMPARE, 32'd7, 1'b0), 101);
        step(rd(R_COUNT, 32'h0, 1'b0, 6'h0), 102);
        step(rd(R_COMPARE, 32'h0, 1'b0, 6'h0), 103);
        step(idle(6'h20, 1'b0), 104);
        step(rd(R_CAUSE, 32'h0000_8000, 1'b0, 6'h20), 105);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
